// File: rtl/shift_pipelined.sv
// Pipelined shifter (SLL/SRL/SRA/ROL): an amount-normalising front stage followed by one power-of-two shift stage per cycle.
// Defining SHIFT_CARRY_EN adds the out_carry port (last bit shifted out) and its pipeline registers.
module shift_pipelined #(
    parameter int WIDTH = 32,
    parameter int NW    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [NW-1:0]    in_n,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_rezultat,
    output logic             out_zero
`ifdef SHIFT_CARRY_EN
    ,
    output logic             out_carry
`endif
);
    localparam int L = $clog2(WIDTH);
    localparam logic [1:0]  OP_SLL = 2'b00;
    localparam logic [1:0]  OP_SRL = 2'b01;
    localparam logic [1:0]  OP_SRA = 2'b10;
    localparam logic [1:0]  OP_ROL = 2'b11;
    localparam logic [NW:0] WLIM   = (NW + 1)'(WIDTH);

    // Index 0 holds the normalised operation; index k+1 holds the output of shift stage k.
    logic             val_r [0:L];
    logic [WIDTH-1:0] a_r   [0:L-1];
    logic [L-1:0]     eff_r [0:L-1];
    logic [1:0]       op_r  [0:L-1];
    logic             sat_r [0:L-1];
    logic [WIDTH-1:0] res_r;
    logic             zero_r;

    logic             adv_s;
    logic [NW:0]      n_ext_s;
    logic [L-1:0]     eff0_s;
    logic             sat0_s;
    logic [WIDTH-1:0] nxt_a_s [0:L-1];
    logic [WIDTH-1:0] res_s;
    logic             zero_s;

`ifdef SHIFT_CARRY_EN
    logic             over_r  [0:L-1];
    logic             cy_r    [0:L-1];
    logic             nxt_c_s [0:L-1];
    logic             over0_s;
    logic             carry_s;
    logic             carry_r;
`endif

    assign in_ready     = !(val_r[L] && !out_ready);
    assign adv_s        = in_ready;
    assign out_valid    = val_r[L];
    assign out_rezultat = res_r;
    assign out_zero     = zero_r;

    // Normalise the amount: rotates wrap modulo WIDTH, shifts clamp at WIDTH into a saturate flag
    always_comb begin
        n_ext_s = {1'b0, in_n};
        eff0_s  = in_n[L-1:0];
        sat0_s  = 1'b0;
        if (in_op == OP_ROL) begin
            eff0_s = in_n[L-1:0];
            sat0_s = 1'b0;
        end else if (n_ext_s >= WLIM) begin
            eff0_s = {L{1'b0}};
            sat0_s = 1'b1;
        end else begin
            eff0_s = in_n[L-1:0];
            sat0_s = 1'b0;
        end
    end

    // Stage k shifts by 2^k when bit k of the normalised amount is set
    always_comb begin
        for (int k = 0; k < L; k++) begin
            nxt_a_s[k] = a_r[k];
            if (|(eff_r[k] & (L'(32'd1) << k))) begin
                case (op_r[k])
                    OP_SLL:  nxt_a_s[k] = a_r[k] << (32'd1 << k);
                    OP_SRL:  nxt_a_s[k] = a_r[k] >> (32'd1 << k);
                    OP_SRA:  nxt_a_s[k] = WIDTH'($signed(a_r[k]) >>> (32'd1 << k));
                    OP_ROL:  nxt_a_s[k] = (a_r[k] << (32'd1 << k)) | (a_r[k] >> (WIDTH - (32'd1 << k)));
                    default: nxt_a_s[k] = a_r[k];
                endcase
            end else begin
                nxt_a_s[k] = a_r[k];
            end
        end
    end

    // Saturated shifts have an all-zero amount, so the last stage still sees the original operand
    always_comb begin
        res_s = nxt_a_s[L-1];
        if (sat_r[L-1]) begin
            case (op_r[L-1])
                OP_SRA:  res_s = {WIDTH{a_r[L-1][WIDTH-1]}};
                default: res_s = {WIDTH{1'b0}};
            endcase
        end else begin
            res_s = nxt_a_s[L-1];
        end
        zero_s = (res_s == {WIDTH{1'b0}});
    end

    // Pipeline registers: all stages advance together, or all hold while the output is blocked
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k <= L; k++) begin
                val_r[k] <= 1'b0;
            end
            for (int k = 0; k < L; k++) begin
                a_r[k]   <= {WIDTH{1'b0}};
                eff_r[k] <= {L{1'b0}};
                op_r[k]  <= 2'b00;
                sat_r[k] <= 1'b0;
            end
            res_r  <= {WIDTH{1'b0}};
            zero_r <= 1'b0;
        end else if (adv_s) begin
            val_r[0] <= in_valid;
            a_r[0]   <= in_a;
            eff_r[0] <= eff0_s;
            op_r[0]  <= in_op;
            sat_r[0] <= sat0_s;
            for (int k = 1; k <= L; k++) begin
                val_r[k] <= val_r[k-1];
            end
            for (int k = 1; k < L; k++) begin
                a_r[k]   <= nxt_a_s[k-1];
                eff_r[k] <= eff_r[k-1];
                op_r[k]  <= op_r[k-1];
                sat_r[k] <= sat_r[k-1];
            end
            res_r  <= res_s;
            zero_r <= zero_s;
        end
    end

`ifdef SHIFT_CARRY_EN
    assign over0_s   = (in_op != OP_ROL) && (n_ext_s > WLIM);
    assign out_carry = carry_r;

    // Carry tracks the last bit leaving the word; later, larger shifts overwrite earlier ones
    always_comb begin
        for (int k = 0; k < L; k++) begin
            nxt_c_s[k] = cy_r[k];
            if (|(eff_r[k] & (L'(32'd1) << k))) begin
                case (op_r[k])
                    OP_SLL:  nxt_c_s[k] = (a_r[k] << ((32'd1 << k) - 32'd1)) >> (WIDTH - 1) != {WIDTH{1'b0}};
                    OP_SRL:  nxt_c_s[k] = ((a_r[k] >> ((32'd1 << k) - 32'd1)) & {{(WIDTH-1){1'b0}}, 1'b1}) != {WIDTH{1'b0}};
                    OP_SRA:  nxt_c_s[k] = ((a_r[k] >> ((32'd1 << k) - 32'd1)) & {{(WIDTH-1){1'b0}}, 1'b1}) != {WIDTH{1'b0}};
                    default: nxt_c_s[k] = cy_r[k];
                endcase
            end else begin
                nxt_c_s[k] = cy_r[k];
            end
        end
        carry_s = nxt_c_s[L-1];
        if (sat_r[L-1]) begin
            case (op_r[L-1])
                OP_SRA:  carry_s = a_r[L-1][WIDTH-1];
                OP_SLL:  carry_s = over_r[L-1] ? 1'b0 : a_r[L-1][0];
                OP_SRL:  carry_s = over_r[L-1] ? 1'b0 : a_r[L-1][WIDTH-1];
                default: carry_s = 1'b0;
            endcase
        end else if (op_r[L-1] == OP_ROL) begin
            carry_s = (eff_r[L-1] != {L{1'b0}}) ? res_s[0] : 1'b0;
        end else begin
            carry_s = nxt_c_s[L-1];
        end
    end

    // Carry pipeline, stalled and reset in step with the data path
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < L; k++) begin
                over_r[k] <= 1'b0;
                cy_r[k]   <= 1'b0;
            end
            carry_r <= 1'b0;
        end else if (adv_s) begin
            over_r[0] <= over0_s;
            cy_r[0]   <= 1'b0;
            for (int k = 1; k < L; k++) begin
                over_r[k] <= over_r[k-1];
                cy_r[k]   <= nxt_c_s[k-1];
            end
            carry_r <= carry_s;
        end
    end
`endif

endmodule

// File: tb/tb_shift_pipelined.sv
// Self-checking bench for shift_pipelined (WIDTH=32): directed vectors, random streaming, stall and reset flush.
module tb_shift_pipelined;
    localparam int W   = 32;
    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, out_zero;
    logic [31:0] in_a, in_n, out_rezultat;
    logic [1:0]  in_op;
`ifdef SHIFT_CARRY_EN
    logic        out_carry;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct { logic [31:0] r; logic z; logic c; } exp_t;
    exp_t expq[$];

    always #5 clk = ~clk;

    shift_pipelined #(.WIDTH(W), .NW(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_n(in_n), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_rezultat(out_rezultat), .out_zero(out_zero)
`ifdef SHIFT_CARRY_EN
        , .out_carry(out_carry)
`endif
    );

    // Reference: the shift rules written directly as arithmetic on the original operand
    function automatic exp_t model(logic [31:0] a, logic [31:0] n, logic [1:0] op);
        exp_t e;
        int   ni;
        int   rr;
        e.c = 1'b0;
        case (op)
            2'b00: begin
                e.r = (n >= 32) ? 32'h0 : (a << n);
                if (n >= 1 && n <= 32) begin ni = int'(n); e.c = a[32 - ni]; end
            end
            2'b01: begin
                e.r = (n >= 32) ? 32'h0 : (a >> n);
                if (n >= 1 && n <= 32) begin ni = int'(n); e.c = a[ni - 1]; end
            end
            2'b10: begin
                e.r = (n >= 32) ? {32{a[31]}} : 32'($signed(a) >>> n);
                if (n > 32) e.c = a[31];
                else if (n >= 1) begin ni = int'(n); e.c = a[ni - 1]; end
            end
            default: begin
                rr  = int'(n % 32);
                e.r = (rr == 0) ? a : ((a << rr) | (a >> (32 - rr)));
                e.c = (rr == 0) ? 1'b0 : e.r[0];
            end
        endcase
        e.z = (e.r == 32'h0);
        return e;
    endfunction

    function automatic logic [31:0] rnd_n();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(30, 34));
            default: return 32'($urandom_range(0, 31));
        endcase
    endfunction

    // One cycle: drive after the falling edge, sample just after; record what the next rising edge accepts
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] n, input logic [1:0] op,
                         input logic ordy, output logic got, output logic [31:0] r, output logic z,
                         output logic c, output logic irdy, output logic ov);
        @(negedge clk);
        in_valid = v; in_a = a; in_n = n; in_op = op; out_ready = ordy;
        #1;
        ov   = out_valid;
        irdy = in_ready;
        got  = out_valid && ordy;
        r    = out_rezultat;
        z    = out_zero;
`ifdef SHIFT_CARRY_EN
        c    = out_carry;
`else
        c    = 1'b0;
`endif
        if (v && in_ready) expq.push_back(model(a, n, op));
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_a = 32'h0; in_n = 32'h0; in_op = 2'b00; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_rezultat !== 32'h0 || out_zero !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: got r=%h z=%b want 0/0", out_rezultat, out_zero);
        end
`ifdef SHIFT_CARRY_EN
        checks++; if (out_carry !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b want 0", out_carry); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] d_a [8] = '{32'h0000_00F1, 32'h8000_0010, 32'h8000_0010, 32'h8000_0010,
                                 32'h8000_0001, 32'h8000_0001, 32'h0000_0001, 32'h1234_5678};
        logic [31:0] d_n [8] = '{32'd4, 32'd4, 32'h0000_0100, 32'd32, 32'd33, 32'd32, 32'd33, 32'd0};
        logic [1:0]  d_o [8] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00};
        logic [31:0] d_r [8] = '{32'h0000_0F10, 32'hF800_0001, 32'hFFFF_FFFF, 32'h0000_0000,
                                 32'h0000_0003, 32'h8000_0001, 32'h0000_0000, 32'h1234_5678};
        logic        d_z [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        d_c [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic got, z, c, irdy, ov;
        logic [31:0] r;
        int lat;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, d_a[i], d_n[i], d_o[i], 1'b1, got, r, z, c, irdy, ov);
            lat = -1;
            for (int k = 1; k <= 20 && lat < 0; k++) begin
                cycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, got, r, z, c, irdy, ov);
                if (got) lat = k - 1;
            end
            expq.delete();
            checks++;
            if (lat != LAT) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, LAT); end
            if (lat >= 0) begin
                checks++; if (r !== d_r[i]) begin errors++; $display("FAIL dir%0d_result: got %h want %h", i, r, d_r[i]); end
                checks++; if (z !== d_z[i]) begin errors++; $display("FAIL dir%0d_zero: got %b want %b", i, z, d_z[i]); end
`ifdef SHIFT_CARRY_EN
                checks++; if (c !== d_c[i]) begin errors++; $display("FAIL dir%0d_carry: got %b want %b", i, c, d_c[i]); end
`endif
            end
        end
    endtask

    task automatic test_back_to_back();
        logic got, z, c, irdy, ov, ok;
        logic [31:0] r;
        exp_t e;
        int recv = 0, first_k = -1, last_k = -1;
        expq.delete();
        for (int k = 0; k < 45; k++) begin
            cycle(k < 20, $urandom, rnd_n(), 2'($urandom_range(0, 3)), 1'b1, got, r, z, c, irdy, ov);
            if (got) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL b2b_extra: got unexpected result %h", r);
                end else begin
                    e  = expq.pop_front();
                    ok = (r === e.r) && (z === e.z);
`ifdef SHIFT_CARRY_EN
                    ok = ok && (c === e.c);
`endif
                    if (!ok) begin
                        errors++;
                        $display("FAIL b2b[%0d]: got r=%h z=%b c=%b want r=%h z=%b c=%b", recv, r, z, c, e.r, e.z, e.c);
                    end
                end
                if (first_k < 0) first_k = k;
                last_k = k;
                recv++;
            end
        end
        checks++; if (recv != 20) begin errors++; $display("FAIL b2b_count: got %0d want 20", recv); end
        checks++; if (last_k - first_k != 19) begin errors++; $display("FAIL b2b_spacing: got %0d want 19", last_k - first_k); end
    endtask

    task automatic test_stall();
        logic got, z, c, irdy, ov, ok, ordy, have_held, held_z, held_c, dropped;
        logic [31:0] r, held_r;
        exp_t e;
        int sent = 0, recv = 0;
        have_held = 1'b0; dropped = 1'b0; held_r = 32'h0; held_z = 1'b0; held_c = 1'b0;
        expq.delete();
        for (int k = 0; k < 55; k++) begin
            ordy = !(k >= 8 && k < 15);
            cycle(k < 25, $urandom, rnd_n(), 2'($urandom_range(0, 3)), ordy, got, r, z, c, irdy, ov);
            if (k < 25 && irdy) sent++;
            checks++;
            if (irdy !== !(ov && !ordy)) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b want %b", k, irdy, !(ov && !ordy)); end
            if (ov && !ordy) begin
                dropped = 1'b1;
                if (have_held) begin
                    checks++;
                    if (r !== held_r || z !== held_z || c !== held_c) begin
                        errors++; $display("FAIL stall_hold[%0d]: got %h/%b/%b want %h/%b/%b", k, r, z, c, held_r, held_z, held_c);
                    end
                end
                held_r = r; held_z = z; held_c = c; have_held = 1'b1;
            end else begin
                have_held = 1'b0;
            end
            if (got) begin
                recv++;
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL stall_extra: got unexpected result %h", r);
                end else begin
                    e  = expq.pop_front();
                    ok = (r === e.r) && (z === e.z);
`ifdef SHIFT_CARRY_EN
                    ok = ok && (c === e.c);
`endif
                    if (!ok) begin
                        errors++;
                        $display("FAIL stall_data[%0d]: got r=%h z=%b c=%b want r=%h z=%b c=%b", recv, r, z, c, e.r, e.z, e.c);
                    end
                end
            end
        end
        checks++; if (!dropped) begin errors++; $display("FAIL stall_ready_drop: got 0 want 1"); end
        checks++; if (recv != sent) begin errors++; $display("FAIL stall_count: got %0d want %0d", recv, sent); end
    endtask

    task automatic test_reset_flush();
        logic got, z, c, irdy, ov;
        logic [31:0] r;
        int seen = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'hA5A5_0000 + 32'(i), 32'(i + 1), 2'b11, 1'b1, got, r, z, c, irdy, ov);
        end
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        expq.delete();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        checks++; if (out_rezultat !== 32'h0 || out_zero !== 1'b0) begin
            errors++; $display("FAIL flush_outputs: got r=%h z=%b want 0/0", out_rezultat, out_zero);
        end
`ifdef SHIFT_CARRY_EN
        checks++; if (out_carry !== 1'b0) begin errors++; $display("FAIL flush_carry: got %b want 0", out_carry); end
`endif
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        for (int k = 0; k < 12; k++) begin
            cycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, got, r, z, c, irdy, ov);
            if (ov) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_leak: got %0d results want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/shift_pipelined.md
# shift_pipelined

Parametrised, pipelined shift unit for the ALU datapath: accepts an operand, a shift amount and an operation, and produces the shifted result after a fixed number of clock cycles. Supports logical left, logical right, arithmetic right and rotate-left at any power-of-two width, with a zero flag and an optional carry-out. It moves the ALU's shift operations from a single combinational path onto a registered path with a valid/ready handshake on both sides.

## Interface
- WIDTH, 32, operand/result width; must be a power of two and at least 4.
- NW, 32, width of the shift-amount input.
- L (localparam), $clog2(WIDTH), pipeline latency in cycles.
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  reset; one clock, reset is synchronous and active-low.
- in_valid  input  1  an operation is presented this cycle.
- in_ready  output  1  the unit accepts an operation this cycle.
- in_a  input  WIDTH  operand.
- in_n  input  NW  shift amount, unsigned.
- in_op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- out_valid  output  1  out_rezultat, out_zero and out_carry are valid.
- out_ready  input  1  downstream accepts the result.
- out_rezultat  output  WIDTH  result.
- out_zero  output  1  high when out_rezultat == 0.
- out_carry  output  1  last bit shifted out; present only with SHIFT_CARRY_EN.

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- in_ready = !(out_valid && !out_ready). This is a global stall: every stage holds its contents while the output is blocked.
- Stage 0 normalises the amount and registers it with in_a and in_op.
  - SLL, SRL and SRA: eff = min(in_n, WIDTH), compared on the full NW bits.
  - ROL: eff = in_n mod WIDTH, taken from the low L bits.
- Stage k (k = 0..L-1) applies a shift of 2^k when bit k of eff is set.
  - An amount of exactly WIDTH is carried as a separate saturate flag, applied in the last stage.
- Results:
  - SLL: zero fill. A saturated shift gives 0.
  - SRL: zero fill. A saturated shift gives 0.
  - SRA: fill with in_a[WIDTH-1]. A saturated shift gives all bits equal to in_a[WIDTH-1].
  - ROL: bits leaving the MSB re-enter at the LSB. An amount of 0 mod WIDTH returns in_a unchanged.
- Each stage carries its own valid bit. Bubbles propagate and are not collapsed.
- out_zero is computed in the last stage from the final result.

## Timing
- Latency is exactly L cycles when there is no stall: an operation accepted at edge T gives out_valid high after edge T+L (5 for WIDTH=32).
- Throughput is one operation per cycle while out_ready is high.
- Reset, when rst_n is low at an edge:
  - All stage valid bits clear.
  - out_valid, out_rezultat, out_zero and out_carry are 0 after that edge.
  - Operations in flight are discarded and never appear at the output.
  - in_ready is 1 during and after reset.
- While out_valid && !out_ready, out_rezultat, out_zero and out_carry are held stable.
- With out_valid low, in_ready stays high even if out_ready is low.
- in_op value 11 is always ROL; there are no reserved codes.

## Configuration
- SHIFT_CARRY_EN defined: out_carry exists and is pipelined alongside the result.
  - SLL with 1 ≤ n ≤ WIDTH: in_a[WIDTH-n]. SLL with n > WIDTH: 0.
  - SRL with 1 ≤ n ≤ WIDTH: in_a[n-1]. SRL with n > WIDTH: 0.
  - SRA with 1 ≤ n ≤ WIDTH: in_a[n-1]. SRA with n > WIDTH: in_a[WIDTH-1].
  - ROL with n mod WIDTH ≠ 0: out_rezultat[0].
  - Any operation with n = 0, or ROL with n mod WIDTH = 0: 0.
- SHIFT_CARRY_EN undefined: the out_carry port and its pipeline registers are absent. All other behaviour is identical.

## Test plan
- WIDTH=32, SLL in_a=0x0000_00F1, in_n=4 -> out_rezultat 0x0000_0F10, out_zero 0, out_carry 0, out_valid exactly 5 cycles after the transfer in.
- SRA in_a=0x8000_0010, in_n=4 -> 0xF800_0001, carry 0. SRA with in_n=0x0000_0100 -> 0xFFFF_FFFF, carry 1. SRL with in_n=32 -> 0x0000_0000, out_zero 1, carry 1.
- ROL in_a=0x8000_0001, in_n=33 -> 0x0000_0003, carry 1. ROL in_n=32 -> 0x8000_0001, carry 0.
- Back-to-back stream of 20 random operations with out_ready=1 -> 20 results in order, one per cycle, each matching a reference model.
- Hold out_ready=0 for 7 cycles while streaming -> in_ready drops once out_valid is high, the output stays stable, and no operation is lost or duplicated after release.
- Drive rst_n low for one edge with 3 operations in flight -> the next cycle shows out_valid 0 and all outputs 0, and none of the 3 results ever appears at the output.
